// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx: sends "<tag0><tag1>:<d2><d1><d0>;" report frames over the UART byte transmitter.
// Define CMD_FRAME_CHECKSUM_EN to insert a two-char hex XOR of bytes 0..5 before the terminator.
module cmd_frame_tx #(
   parameter int SEP_CHAR    = 58,
   parameter int TERM_CHAR   = 59,
   parameter int ACK_TIMEOUT = 1024,
   parameter int VAL_MAX     = 999
) (
   input  logic       clk0,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] tag0,
   input  logic [7:0] tag1,
   input  logic [9:0] value,
   input  logic       tx_busy,
   output logic [7:0] uart_tx_data,
   output logic       uart_tx_en,
   output logic       busy,
   output logic       done,
   output logic       drop,
   output logic       err
);

   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [9:0] VMAX = 10'(VAL_MAX);
`ifdef CMD_FRAME_CHECKSUM_EN
   localparam logic [3:0] LAST_IDX = 4'd8;
`else
   localparam logic [3:0] LAST_IDX = 4'd6;
`endif

   typedef enum logic [2:0] {IDLE, CONV, SEND, WAIT_HI, WAIT_LO, NEXT, DONE} state_t;

   state_t state, state_nx;

   logic [7:0]    tag0_q, tag1_q;
   logic [9:0]    rem_q;
   logic [3:0]    d2_q, d1_q;
   logic [3:0]    idx_q;
   logic [TW-1:0] tmo_q;
   logic          err_q;
   logic [7:0]    cur_byte;
   logic          accept;

`ifdef CMD_FRAME_CHECKSUM_EN
   logic [7:0] csum_q;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'd48 + {4'd0, n}) : (8'd55 + {4'd0, n});
   endfunction
`endif

   // DONE counts as free so a new request can be taken in the same cycle as the done pulse
   assign accept       = start && ((state == IDLE) || (state == DONE));
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);
   assign drop         = start && (state != IDLE) && (state != DONE);
   assign err          = err_q;

   // After conversion rem_q holds the units digit, so it doubles as d0
   always_comb begin
      cur_byte = 8'(TERM_CHAR);
      case (idx_q)
         4'd0:    cur_byte = tag0_q;
         4'd1:    cur_byte = tag1_q;
         4'd2:    cur_byte = 8'(SEP_CHAR);
         4'd3:    cur_byte = 8'd48 + {4'd0, d2_q};
         4'd4:    cur_byte = 8'd48 + {4'd0, d1_q};
         4'd5:    cur_byte = 8'd48 + {4'd0, rem_q[3:0]};
`ifdef CMD_FRAME_CHECKSUM_EN
         4'd6:    cur_byte = hex_char(csum_q[7:4]);
         4'd7:    cur_byte = hex_char(csum_q[3:0]);
`endif
         default: cur_byte = 8'(TERM_CHAR);
      endcase
   end

   always_comb begin
      state_nx     = state;
      uart_tx_en   = 1'b0;
      uart_tx_data = 8'd0;
      case (state)
         IDLE:    if (start) state_nx = CONV;
         CONV:    if (rem_q < 10'd10) state_nx = SEND;
         SEND: begin
            if (!tx_busy) begin
               uart_tx_en   = 1'b1;
               uart_tx_data = cur_byte;
               state_nx     = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (tx_busy)                state_nx = WAIT_LO;
            else if (tmo_q == TMO_LAST) state_nx = NEXT;
         end
         WAIT_LO: if (!tx_busy) state_nx = NEXT;
         NEXT:    state_nx = (idx_q == LAST_IDX) ? DONE : SEND;
         DONE:    state_nx = start ? CONV : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // A lost acknowledge is flagged but the byte is counted as sent so the frame still finishes
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         tag0_q <= 8'd0;
         tag1_q <= 8'd0;
         rem_q  <= 10'd0;
         d2_q   <= 4'd0;
         d1_q   <= 4'd0;
         idx_q  <= 4'd0;
         tmo_q  <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         tag0_q <= tag0;
         tag1_q <= tag1;
         rem_q  <= (value > VMAX) ? VMAX : value;
         d2_q   <= 4'd0;
         d1_q   <= 4'd0;
         idx_q  <= 4'd0;
         tmo_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            CONV: begin
               if (rem_q >= 10'd100) begin
                  rem_q <= rem_q - 10'd100;
                  d2_q  <= d2_q + 4'd1;
               end else if (rem_q >= 10'd10) begin
                  rem_q <= rem_q - 10'd10;
                  d1_q  <= d1_q + 4'd1;
               end
            end
            SEND:    if (!tx_busy) tmo_q <= '0;
            WAIT_HI: begin
               if (!tx_busy) begin
                  if (tmo_q == TMO_LAST) err_q <= 1'b1;
                  else                   tmo_q <= tmo_q + 1'b1;
               end
            end
            NEXT:    if (idx_q != LAST_IDX) idx_q <= idx_q + 4'd1;
            default: ;
         endcase
      end
   end

`ifdef CMD_FRAME_CHECKSUM_EN
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n)                                             csum_q <= 8'd0;
      else if (accept)                                        csum_q <= 8'd0;
      else if (state == SEND && !tx_busy && idx_q < 4'd6)     csum_q <= csum_q ^ cur_byte;
   end
`endif

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Directed bench for cmd_frame_tx: a UART responder model plus a byte scoreboard per frame.
module tb_cmd_frame_tx;

`ifdef CMD_FRAME_CHECKSUM_EN
   localparam int FRAME_LEN = 9;
`else
   localparam int FRAME_LEN = 7;
`endif

   logic       clk0 = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] tag0 = 8'd0;
   logic [7:0] tag1 = 8'd0;
   logic [9:0] value = 10'd0;
   logic       tx_busy = 1'b0;
   logic [7:0] uart_tx_data;
   logic       uart_tx_en;
   logic       busy;
   logic       done;
   logic       drop;
   logic       err;

   int total = 0;
   int bad = 0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int strobe_cnt = 0;
   int done_cnt = 0;
   int drop_cnt = 0;
   int busy_low_cnt = 0;
   bit stuck_low = 1'b0;

   cmd_frame_tx dut (
      .clk0         (clk0),
      .rst_n        (rst_n),
      .start        (start),
      .tag0         (tag0),
      .tag1         (tag1),
      .value        (value),
      .tx_busy      (tx_busy),
      .uart_tx_data (uart_tx_data),
      .uart_tx_en   (uart_tx_en),
      .busy         (busy),
      .done         (done),
      .drop         (drop),
      .err          (err)
   );

   always #5 clk0 = ~clk0;

   // UART model: samples DUT outputs mid-cycle, holds tx_busy high for 10 cycles after each strobe
   initial begin
      int  busy_left;
      bit  strobe_seen;
      busy_left = 0;
      forever begin
         @(negedge clk0);
         strobe_seen = uart_tx_en;
         if (uart_tx_en) begin
            obs_q.push_back(uart_tx_data);
            strobe_cnt++;
         end
         if (done)  done_cnt++;
         if (drop)  drop_cnt++;
         if (!busy) busy_low_cnt++;
         @(posedge clk0);
         #1;
         if (stuck_low) begin
            tx_busy   = 1'b0;
            busy_left = 0;
         end else if (strobe_seen) begin
            tx_busy   = 1'b1;
            busy_left = 10;
         end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, want);
      end
   endtask

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? 8'(48 + int'(n)) : 8'(65 + int'(n) - 10);
   endfunction

   task automatic build_frame(input logic [7:0] t0, input logic [7:0] t1, input int v);
      int         c;
      logic [7:0] f[6];
      logic [7:0] x;
      c    = (v > 999) ? 999 : v;
      f[0] = t0;
      f[1] = t1;
      f[2] = 8'd58;
      f[3] = 8'(48 + c / 100);
      f[4] = 8'(48 + (c / 10) % 10);
      f[5] = 8'(48 + c % 10);
      x    = 8'd0;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(f[i]);
         x = x ^ f[i];
      end
`ifdef CMD_FRAME_CHECKSUM_EN
      exp_q.push_back(hex_ascii(x[7:4]));
      exp_q.push_back(hex_ascii(x[3:0]));
`endif
      exp_q.push_back(8'd59);
   endtask

   task automatic apply_stimulus(input logic [7:0] t0, input logic [7:0] t1, input int v,
                                 input bit push_exp);
      @(posedge clk0);
      #1;
      start = 1'b1;
      tag0  = t0;
      tag1  = t1;
      value = 10'(v);
      if (push_exp) build_frame(t0, t1, v);
      @(posedge clk0);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (n < budget && !seen) begin
         @(negedge clk0);
         if (done) seen = 1'b1;
         n++;
      end
      check_output(tag, 32'(seen), 32'd1);
      @(posedge clk0);
      #1;
   endtask

   task automatic check_frame(input string tag);
      int i;
      logic [7:0] e;
      logic [7:0] o;
      check_output({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
      i = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         check_output($sformatf("%s_b%0d", tag, i), 32'(o), 32'(e));
         i++;
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_data"}, 32'(uart_tx_data), 32'd0);
      check_output({tag, "_en"},   32'(uart_tx_en),   32'd0);
      check_output({tag, "_busy"}, 32'(busy),         32'd0);
      check_output({tag, "_done"}, 32'(done),         32'd0);
      check_output({tag, "_drop"}, 32'(drop),         32'd0);
      check_output({tag, "_err"},  32'(err),          32'd0);
   endtask

   initial begin
      int s0, d0, dr0, bl0, n;

      repeat (3) @(posedge clk0);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // basic frame "DS:217;"
      s0 = strobe_cnt;
      d0 = done_cnt;
      apply_stimulus(8'd68, 8'd83, 217, 1'b1);
      check_output("basic_busy", 32'(busy), 32'd1);
      wait_done(1000, "basic_done_seen");
      check_output("basic_strobes", 32'(strobe_cnt - s0), 32'(FRAME_LEN));
      check_output("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
      check_output("basic_err", 32'(err), 32'd0);
      check_output("basic_busy_after", 32'(busy), 32'd0);
      check_frame("basic");

      // saturation and zero
      apply_stimulus(8'd84, 8'd86, 1023, 1'b1);
      wait_done(1000, "sat_done_seen");
      check_frame("sat");
      apply_stimulus(8'd84, 8'd86, 0, 1'b1);
      wait_done(1000, "zero_done_seen");
      check_frame("zero");

      // overrun: second request five cycles after the first is dropped
      dr0 = drop_cnt;
      apply_stimulus(8'd65, 8'd66, 500, 1'b1);
      bl0 = busy_low_cnt;
      repeat (3) @(posedge clk0);
      #1;
      apply_stimulus(8'd88, 8'd89, 100, 1'b0);
      wait_done(1000, "ovr_done_seen");
      check_output("ovr_drop_cnt", 32'(drop_cnt - dr0), 32'd1);
      check_output("ovr_busy_low", 32'(busy_low_cnt - bl0), 32'd0);
      check_frame("ovr");

      // lost acknowledge: tx_busy never rises
      stuck_low = 1'b1;
      repeat (2) @(posedge clk0);
      #1;
      s0 = strobe_cnt;
      apply_stimulus(8'd76, 8'd65, 42, 1'b1);
      wait_done(12000, "lost_done_seen");
      check_output("lost_err", 32'(err), 32'd1);
      check_output("lost_strobes", 32'(strobe_cnt - s0), 32'(FRAME_LEN));
      check_frame("lost");
      stuck_low = 1'b0;
      apply_stimulus(8'd67, 8'd76, 5, 1'b1);
      check_output("err_cleared", 32'(err), 32'd0);
      wait_done(1000, "clr_done_seen");
      check_output("clr_err_end", 32'(err), 32'd0);
      check_frame("clr");

      // reset after the third strobe aborts the frame
      s0 = strobe_cnt;
      apply_stimulus(8'd82, 8'd83, 321, 1'b1);
      n = 0;
      while ((strobe_cnt - s0) < 3 && n < 500) begin
         @(posedge clk0);
         #1;
         n++;
      end
      check_output("mid_third_strobe", 32'((strobe_cnt - s0) >= 3), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      d0 = done_cnt;
      repeat (3) @(posedge clk0);
      #1;
      check_output("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      check_output("midrst_partial", 32'(obs_q.size()), 32'd3);
      rst_n = 1'b1;
      exp_q.delete();
      obs_q.delete();
      apply_stimulus(8'd68, 8'd83, 217, 1'b1);
      wait_done(1000, "after_rst_done_seen");
      check_output("after_rst_err", 32'(err), 32'd0);
      check_frame("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
